grp_orbit_reader: RTL and testbench

Read-side counterpart of the MCM packer. It drains one stream of 12-bit orbit words from a group RAM and presents them one at a time to the downstream LCB serializer through a valid/ready handshake. While it reads, it holds the busy line that the packer watches; the falling edge of that line tells the packer the group RAM is free for the next stream. Addressing mirrors the packer layout: stride 32 inside a stream, +8 between streams, 3 streams per cycle, then back to 0.

---
 rtl/grp_orbit_reader_pkg.sv | 33 +++
 rtl/grp_addr_gen.sv | 43 ++++
 rtl/grp_orbit_reader.sv | 116 +++++++++++
 tb/tb_grp_orbit_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grp_orbit_reader_pkg.sv
// Shared group-RAM geometry, packer/reader layout defaults and reader state encoding.
// The packer imports the same layout constants, so the two sides cannot drift apart.
package grp_orbit_reader_pkg;

   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 12;
   localparam int STREAM_W = 2;

   localparam int DEF_RD_LAT      = 3;
   localparam int DEF_WORDS       = 32;
   localparam int DEF_STRIDE      = 32;
   localparam int DEF_STREAM_STEP = 8;
   localparam int DEF_STREAMS     = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_HOLD,
      ST_NEXT
   } state_t;

   // Group RAM address of word k in a stream; the 10-bit address wraps silently.
   function automatic logic [ADDR_W-1:0] word_addr(input int unsigned stream,
                                                   input int unsigned word,
                                                   input int unsigned stream_step,
                                                   input int unsigned stride);
      int unsigned full;
      full = stream * stream_step + word * stride;
      return ADDR_W'(full);
   endfunction

endpackage

// File: rtl/grp_addr_gen.sv
// Stream/word counters of the orbit reader. Presents the current and next word
// address combinationally, plus the last-word flag of the current stream.
module grp_addr_gen
   import grp_orbit_reader_pkg::*;
#(
   parameter int WORDS       = DEF_WORDS,
   parameter int STRIDE      = DEF_STRIDE,
   parameter int STREAM_STEP = DEF_STREAM_STEP,
   parameter int STREAMS     = DEF_STREAMS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                step,
   output logic [ADDR_W-1:0]   addr,
   output logic [ADDR_W-1:0]   addr_next,
   output logic                last,
   output logic [STREAM_W-1:0] stream
);

   localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [WORD_W-1:0] word;

   assign last      = (word == WORD_W'(WORDS - 1));
   assign addr      = word_addr(32'(stream), 32'(word), STREAM_STEP, STRIDE);
   assign addr_next = word_addr(32'(stream), 32'(word) + 32'd1, STREAM_STEP, STRIDE);

   // Finishing a stream rewinds the word counter and moves on to the next stream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word   <= '0;
         stream <= '0;
      end else if (step) begin
         if (last) begin
            word   <= '0;
            stream <= (stream == STREAM_W'(STREAMS - 1)) ? '0 : stream + 1'b1;
         end else begin
            word <= word + 1'b1;
         end
      end
   end

endmodule

// File: rtl/grp_orbit_reader.sv
// Drains one stream of orbit words from the group RAM into the LCB serializer.
// oBusy guards the RAM against the packer for the whole stream.
module grp_orbit_reader
   import grp_orbit_reader_pkg::*;
#(
   parameter int RD_LAT      = DEF_RD_LAT,
   parameter int WORDS       = DEF_WORDS,
   parameter int STRIDE      = DEF_STRIDE,
   parameter int STREAM_STEP = DEF_STREAM_STEP,
   parameter int STREAMS     = DEF_STREAMS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iStart,
   input  logic [DATA_W-1:0]   iRdData,
   output logic [ADDR_W-1:0]   oRdAddr,
   output logic                oRdEn,
   output logic [DATA_W-1:0]   oData,
   output logic                oValid,
   input  logic                iReady,
   output logic                oLast,
   output logic [STREAM_W-1:0] oStream,
   output logic                oBusy
);

   localparam int LAT_W = 3;

   state_t              state;
   logic [LAT_W-1:0]    lat_cnt;
   logic                step;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W-1:0]   addr_next;
   logic                last;
   logic [STREAM_W-1:0] stream;

   assign step    = (state == ST_HOLD) && oValid && iReady;
   assign oStream = stream;

   grp_addr_gen #(
      .WORDS       (WORDS),
      .STRIDE      (STRIDE),
      .STREAM_STEP (STREAM_STEP),
      .STREAMS     (STREAMS)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .addr      (addr),
      .addr_next (addr_next),
      .last      (last),
      .stream    (stream)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         lat_cnt <= '0;
         oRdAddr <= '0;
         oRdEn   <= 1'b0;
         oData   <= '0;
         oValid  <= 1'b0;
         oLast   <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         // NOTE: default-low here turns every oRdEn <= 1 below into a one-cycle
         // pulse; non-blocking assignment lets the later branch override it.
         oRdEn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  state   <= ST_READ;
                  oBusy   <= 1'b1;
                  oRdEn   <= 1'b1;
                  oRdAddr <= addr;
                  lat_cnt <= '0;
               end
            end
            ST_READ: begin
               if (lat_cnt == LAT_W'(RD_LAT - 1)) state <= ST_CAPTURE;
               else lat_cnt <= lat_cnt + 1'b1;
            end
            ST_CAPTURE: begin
               oData  <= iRdData;
               oValid <= 1'b1;
               oLast  <= last;
               state  <= ST_HOLD;
            end
            ST_HOLD: begin
               // Word step and next read issue share the transfer edge.
               if (iReady) begin
                  oValid <= 1'b0;
                  oLast  <= 1'b0;
                  if (last) begin
                     state <= ST_IDLE;
                     oBusy <= 1'b0;
                  end else begin
                     state   <= ST_READ;
                     oRdEn   <= 1'b1;
                     oRdAddr <= addr_next;
                     lat_cnt <= '0;
                  end
               end
            end
            ST_NEXT: begin
               state <= ST_IDLE;
               oBusy <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               oBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grp_orbit_reader.sv
// Scoreboard bench for grp_orbit_reader: a latency-3 RAM model returns data = address,
// expected reads and transfers are queued at stimulus time and popped by a monitor.
module tb_grp_orbit_reader;
   import grp_orbit_reader_pkg::*;

   localparam int RD_LAT = 3;
   localparam int STREAM_CYC = 160;

   typedef struct {
      int data;
      bit last;
   } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, ready;
   logic [11:0] rd_data;
   logic [9:0]  rd_addr;
   logic        rd_en, valid, last, busy;
   logic [11:0] data;
   logic [1:0]  stream;

   logic        w_start;
   logic        w_ready;
   logic [11:0] w_rd_data;
   logic [9:0]  w_rd_addr;
   logic        w_rd_en, w_valid, w_last, w_busy;
   logic [11:0] w_data;
   logic [1:0]  w_stream;

   int n_cmp = 0;
   int n_err = 0;
   int xfer_cnt = 0;
   int busy_cnt = 0;
   bit chk_busy = 1'b1;

   int    exp_addr[$];
   word_t exp_word[$];
   int    w_exp_addr[$];

   grp_orbit_reader #(.RD_LAT(RD_LAT)) u_dut (
      .clk(clk), .reset(rst_n), .iStart(start), .iRdData(rd_data),
      .oRdAddr(rd_addr), .oRdEn(rd_en), .oData(data), .oValid(valid),
      .iReady(ready), .oLast(last), .oStream(stream), .oBusy(busy)
   );

   grp_orbit_reader #(.RD_LAT(RD_LAT), .STREAM_STEP(1000)) u_wrap (
      .clk(clk), .reset(rst_n), .iStart(w_start), .iRdData(w_rd_data),
      .oRdAddr(w_rd_addr), .oRdEn(w_rd_en), .oData(w_data), .oValid(w_valid),
      .iReady(w_ready), .oLast(w_last), .oStream(w_stream), .oBusy(w_busy)
   );

   // Group RAM models: read sampled on the edge after oRdEn, data RD_LAT clocks later.
   logic [9:0] pipe_a [RD_LAT];
   logic       pipe_v [RD_LAT];
   logic [9:0] w_pipe_a [RD_LAT];
   logic       w_pipe_v [RD_LAT];

   initial begin
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_a[i] = '0; pipe_v[i] = 1'b0; w_pipe_a[i] = '0; w_pipe_v[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_a[i]   <= pipe_a[i-1];
         pipe_v[i]   <= pipe_v[i-1];
         w_pipe_a[i] <= w_pipe_a[i-1];
         w_pipe_v[i] <= w_pipe_v[i-1];
      end
      pipe_a[0]   <= rd_addr;
      pipe_v[0]   <= rd_en;
      w_pipe_a[0] <= w_rd_addr;
      w_pipe_v[0] <= w_rd_en;
   end

   assign rd_data   = pipe_v[RD_LAT-1]   ? {2'b00, pipe_a[RD_LAT-1]}   : 12'hFFF;
   assign w_rd_data = w_pipe_v[RD_LAT-1] ? {2'b00, w_pipe_a[RD_LAT-1]} : 12'hFFF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_stream(input int s, input int step);
      for (int k = 0; k < 32; k++) begin
         int a;
         word_t w;
         a = (s * step + k * 32) % 1024;
         w.data = a;
         w.last = (k == 31);
         exp_addr.push_back(a);
         exp_word.push_back(w);
      end
   endtask

   // Monitor: every read and every transfer is scored against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rd_en) begin
               if (exp_addr.size() == 0) check("rd_extra", exp_addr.size(), 1);
               else check("rd_addr", rd_addr, exp_addr.pop_front());
            end
            if (valid && ready) begin
               xfer_cnt++;
               if (exp_word.size() == 0) check("xfer_extra", exp_word.size(), 1);
               else begin
                  word_t w;
                  w = exp_word.pop_front();
                  check("data", data, w.data);
                  check("last", last, w.last);
               end
            end
            if (busy) busy_cnt++;
            else begin
               if (busy_cnt != 0 && chk_busy) check("busy_len", busy_cnt, STREAM_CYC);
               busy_cnt = 0;
            end
            if (w_rd_en) begin
               if (w_exp_addr.size() == 0) check("w_rd_extra", w_exp_addr.size(), 1);
               else check("w_rd_addr", w_rd_addr, w_exp_addr.pop_front());
            end
         end else begin
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_busy(input logic lvl, input string tag);
      for (int i = 0; i < 400 && busy !== lvl; i++) @(negedge clk);
      check(tag, busy, lvl);
   endtask

   task automatic wait_xfers(input int base, input int n);
      for (int i = 0; i < 400 && (xfer_cnt - base) < n; i++) @(posedge clk);
      check("xfer_wait", xfer_cnt - base, n);
   endtask

   task automatic run_stream(input bit chk);
      @(posedge clk); #1 start = 1'b1; chk_busy = chk;
      @(posedge clk); #1 start = 1'b0;
      wait_busy(1'b0, "stream_end");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},   rd_addr, 0);
      check({tag, "_rden"},   rd_en,   0);
      check({tag, "_data"},   data,    0);
      check({tag, "_valid"},  valid,   0);
      check({tag, "_last"},   last,    0);
      check({tag, "_stream"}, stream,  0);
      check({tag, "_busy"},   busy,    0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int gap;
      rst_n = 1'b0; start = 1'b0; ready = 1'b1; w_start = 1'b0; w_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      @(negedge clk) rst_n = 1'b1;

      // Three full streams, iReady tied high.
      push_stream(0, 8); run_stream(1'b1); check("stream_after0", stream, 1);
      push_stream(1, 8); run_stream(1'b1); check("stream_after1", stream, 2);
      push_stream(2, 8); run_stream(1'b1); check("stream_after2", stream, 0);

      // Backpressure on word 5 of stream 0.
      push_stream(0, 8);
      @(posedge clk); #1 start = 1'b1; chk_busy = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      base = xfer_cnt - 0;
      base = xfer_cnt;
      wait_xfers(base, 5);
      #1 ready = 1'b0;
      for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
      check("bp_valid_rise", valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", valid, 1);
         check("bp_data", data, 5 * 32);
         check("bp_rden", rd_en, 0);
      end
      @(posedge clk); #1 ready = 1'b1;
      @(posedge clk); #1;
      check("bp_next_rden", rd_en, 1);
      check("bp_valid_drop", valid, 0);
      wait_busy(1'b0, "bp_end");
      check("stream_after_bp", stream, 1);

      // iStart pulses during an active stream must be ignored.
      push_stream(1, 8);
      @(posedge clk); #1 start = 1'b1; chk_busy = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (20) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      wait_busy(1'b0, "noise_end");
      check("stream_after_noise", stream, 2);

      // iStart held high: exactly one idle cycle between streams 2 and 0.
      push_stream(2, 8); push_stream(0, 8);
      @(posedge clk); #1 start = 1'b1;
      wait_busy(1'b1, "held_rise");
      wait_busy(1'b0, "held_fall");
      gap = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy) break;
         gap++;
      end
      check("held_gap", gap, 1);
      @(posedge clk); #1 start = 1'b0;
      wait_busy(1'b0, "held_end");
      check("stream_after_held", stream, 1);

      // Reset during word 17 of stream 1, then restart from stream 0 address 0.
      push_stream(1, 8);
      @(posedge clk); #1 start = 1'b1; chk_busy = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      base = xfer_cnt;
      wait_xfers(base, 17);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      exp_addr.delete();
      exp_word.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_stream(0, 8); run_stream(1'b1); check("stream_after_rst", stream, 1);

      // Wrap instance: stream 1 base 1000 wraps through the 10-bit address space.
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 32; k++) w_exp_addr.push_back((s * 1000 + k * 32) % 1024);
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1 w_start = 1'b1;
         @(posedge clk); #1 w_start = 1'b0;
         for (int i = 0; i < 400 && w_busy; i++) @(negedge clk);
         check("w_stream_end", w_busy, 0);
      end
      check("w_stream_idx", w_stream, 2);

      repeat (3) @(posedge clk);
      check("addr_left", exp_addr.size(), 0);
      check("word_left", exp_word.size(), 0);
      check("w_addr_left", w_exp_addr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
